// File: rtl/multi_alarm_ctrl_if.sv
// Alarm controller bus: timekeeping inputs, slot programming, user controls and ring status.
interface multi_alarm_ctrl_if #(
    parameter int N_ALARM = 4,
    parameter int TW      = 7
);
    localparam int IW = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;

    logic          sec_tick;
    logic [TW-1:0] h;
    logic [TW-1:0] m;
    logic          alarmon;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [TW-1:0] wr_h;
    logic [TW-1:0] wr_m;
    logic          wr_act;
    logic          dismiss;
    logic          snooze;
    logic          r;
    logic [IW-1:0] ring_idx;
    logic          snoozing;
    logic          missed;

    modport master (
        output sec_tick, h, m, alarmon, wr_en, wr_idx, wr_h, wr_m, wr_act, dismiss, snooze,
        input  r, ring_idx, snoozing, missed
    );

    modport slave (
        input  sec_tick, h, m, alarmon, wr_en, wr_idx, wr_h, wr_m, wr_act, dismiss, snooze,
        output r, ring_idx, snoozing, missed
    );
endinterface

// File: rtl/multi_alarm_ctrl.sv
// Multi-slot alarm controller: per-slot time compare on minute entry, ring/snooze/timeout FSM.
module multi_alarm_slot #(
    parameter int TW = 7
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          we,
    input  logic [TW-1:0] wh,
    input  logic [TW-1:0] wm,
    input  logic          wact,
    input  logic [TW-1:0] h,
    input  logic [TW-1:0] m,
    output logic          hit
);
    logic [TW-1:0] sh, sm;
    logic          sact;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sh   <= '0;
            sm   <= '0;
            sact <= 1'b0;
        end else if (we) begin
            sh   <= wh;
            sm   <= wm;
            sact <= wact;
        end
    end

    // Compares against the stored (pre-write) contents.
    assign hit = sact && (h == sh) && (m == sm);
endmodule

module multi_alarm_ctrl #(
    parameter int N_ALARM    = 4,
    parameter int TW         = 7,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_TICKS = 60
) (
    input logic               CLK,
    input logic               reset,
    multi_alarm_ctrl_if.slave bus
);
    localparam int IW = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;
    localparam int CW = $clog2(RING_TICKS + 1);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    state_t        state;
    logic [TW-1:0] m_prev;
    logic          primed;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tgt_h, tgt_m;
    logic [IW-1:0] ring_idx;
    logic          missed;

    logic [N_ALARM-1:0] hit;
    logic               match_any;
    logic [IW-1:0]      match_idx;
    logic               min_edge;
    logic [TW:0]        sm_sum;
    logic [TW-1:0]      snz_h, snz_m;

    genvar g;
    generate
        for (g = 0; g < N_ALARM; g++) begin : g_slot
            multi_alarm_slot #(.TW(TW)) u_slot (
                .CLK   (CLK),
                .reset (reset),
                .we    (bus.wr_en && (bus.wr_idx == IW'(g))),
                .wh    (bus.wr_h),
                .wm    (bus.wr_m),
                .wact  (bus.wr_act),
                .h     (bus.h),
                .m     (bus.m),
                .hit   (hit[g])
            );
        end
    endgenerate

    // Descending scan so the lowest matching slot wins.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = N_ALARM - 1; i >= 0; i--) begin
            if (hit[i]) begin
                match_any = 1'b1;
                match_idx = IW'(i);
            end
        end
    end

    assign min_edge = primed && (bus.m != m_prev);

    always_comb begin
        sm_sum = {1'b0, bus.m} + (TW+1)'(SNOOZE_MIN);
        if (sm_sum >= (TW+1)'(60)) begin
            snz_m = TW'(sm_sum - (TW+1)'(60));
            snz_h = (bus.h == TW'(23)) ? '0 : bus.h + TW'(1);
        end else begin
            snz_m = TW'(sm_sum);
            snz_h = bus.h;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            m_prev   <= '0;
            primed   <= 1'b0;
            cnt      <= '0;
            tgt_h    <= '0;
            tgt_m    <= '0;
            ring_idx <= '0;
            missed   <= 1'b0;
        end else begin
            m_prev <= bus.m;
            primed <= 1'b1;
            missed <= 1'b0;
            if (!bus.alarmon) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (min_edge && match_any) begin
                            state    <= RING;
                            ring_idx <= match_idx;
                            cnt      <= '0;
                        end
                    end
                    RING: begin
                        if (bus.dismiss) begin
                            state <= IDLE;
                        end else if (bus.snooze) begin
                            state <= SNOOZE;
                            tgt_h <= snz_h;
                            tgt_m <= snz_m;
                            cnt   <= '0;
                        end else if (bus.sec_tick) begin
                            if (cnt == CW'(RING_TICKS - 1)) begin
                                state  <= IDLE;
                                missed <= 1'b1;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                    SNOOZE: begin
                        if (bus.dismiss) begin
                            state <= IDLE;
                        end else if (min_edge && (bus.h == tgt_h) && (bus.m == tgt_m)) begin
                            state <= RING;
                            cnt   <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.r        = (state == RING);
    assign bus.snoozing = (state == SNOOZE);
    assign bus.ring_idx = ring_idx;
    assign bus.missed   = missed;
endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed bench for multi_alarm_ctrl: matching, priority, snooze wrap, timeout, alarmon, reset.
module tb_multi_alarm_ctrl;
    logic CLK = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   miss_seen;

    always #5 CLK = ~CLK;

    multi_alarm_ctrl_if #(.N_ALARM(4), .TW(7)) bus ();

    multi_alarm_ctrl #(
        .N_ALARM(4), .TW(7), .SNOOZE_MIN(5), .RING_TICKS(60)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] idx, input logic [6:0] wh, input logic [6:0] wm,
                      input logic act);
        bus.wr_en  = 1'b1;
        bus.wr_idx = idx;
        bus.wr_h   = wh;
        bus.wr_m   = wm;
        bus.wr_act = act;
        step(1);
        bus.wr_en  = 1'b0;
    endtask

    task automatic pulse_dismiss();
        bus.dismiss = 1'b1;
        step(1);
        bus.dismiss = 1'b0;
    endtask

    task automatic ring_2358();
        bus.h = 7'd23;
        bus.m = 7'd57;
        step(2);
        bus.m = 7'd58;
        step(1);
    endtask

    initial begin
        reset        = 1'b1;
        bus.sec_tick = 1'b0;
        bus.h        = 7'd7;
        bus.m        = 7'd29;
        bus.alarmon  = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_idx   = '0;
        bus.wr_h     = '0;
        bus.wr_m     = '0;
        bus.wr_act   = 1'b0;
        bus.dismiss  = 1'b0;
        bus.snooze   = 1'b0;
        #3;
        chk("rst_r", bus.r, 1'b0);
        chk("rst_idx", bus.ring_idx, 2'd0);
        chk("rst_snz", bus.snoozing, 1'b0);
        chk("rst_missed", bus.missed, 1'b0);
        step(2);
        reset = 1'b0;

        // 1: basic match, dismiss, no retrigger while minute held
        wr(2'd0, 7'd7, 7'd30, 1'b1);
        bus.alarmon = 1'b1;
        step(2);
        chk("t1_pre", bus.r, 1'b0);
        bus.m = 7'd30;
        step(1);
        chk("t1_ring", bus.r, 1'b1);
        chk("t1_idx", bus.ring_idx, 2'd0);
        pulse_dismiss();
        chk("t1_dismiss", bus.r, 1'b0);
        step(3);
        chk("t1_noretrig", bus.r, 1'b0);

        // 2: lowest active matching slot wins, inactive slot skipped
        wr(2'd0, 7'd6, 7'd0, 1'b0);
        wr(2'd1, 7'd6, 7'd0, 1'b1);
        wr(2'd3, 7'd6, 7'd0, 1'b1);
        bus.h = 7'd6;
        bus.m = 7'd59;
        step(2);
        chk("t2_pre", bus.r, 1'b0);
        bus.m = 7'd0;
        step(1);
        chk("t2_ring", bus.r, 1'b1);
        chk("t2_idx", bus.ring_idx, 2'd1);
        pulse_dismiss();

        // 3: snooze across midnight, 23:58 + 5 -> 00:03
        wr(2'd2, 7'd23, 7'd58, 1'b1);
        ring_2358();
        chk("t3_ring", bus.r, 1'b1);
        chk("t3_idx", bus.ring_idx, 2'd2);
        bus.snooze = 1'b1;
        step(1);
        bus.snooze = 1'b0;
        chk("t3_snz_r", bus.r, 1'b0);
        chk("t3_snz", bus.snoozing, 1'b1);
        bus.m = 7'd59;
        step(2);
        chk("t3_2359_r", bus.r, 1'b0);
        chk("t3_2359_snz", bus.snoozing, 1'b1);
        bus.h = 7'd0;
        bus.m = 7'd3;
        step(1);
        chk("t3_0003_r", bus.r, 1'b1);
        chk("t3_0003_idx", bus.ring_idx, 2'd2);
        chk("t3_0003_snz", bus.snoozing, 1'b0);
        pulse_dismiss();
        chk("t3_dis_r", bus.r, 1'b0);

        // 4: auto-timeout after 60 ticks with single-cycle missed pulse
        ring_2358();
        chk("t4_ring", bus.r, 1'b1);
        miss_seen = 0;
        for (int i = 0; i < 59; i++) begin
            bus.sec_tick = 1'b1;
            step(1);
            bus.sec_tick = 1'b0;
            if (bus.missed) miss_seen++;
            step(1);
            if (bus.missed) miss_seen++;
        end
        chk("t4_r59", bus.r, 1'b1);
        chk("t4_nomiss59", miss_seen, 0);
        bus.sec_tick = 1'b1;
        step(1);
        bus.sec_tick = 1'b0;
        chk("t4_r60", bus.r, 1'b0);
        chk("t4_missed", bus.missed, 1'b1);
        step(1);
        chk("t4_missed_1cyc", bus.missed, 1'b0);

        // 5: dismiss beats snooze; alarmon low blocks match and stops ringing
        ring_2358();
        chk("t5_ring", bus.r, 1'b1);
        bus.dismiss = 1'b1;
        bus.snooze  = 1'b1;
        step(1);
        bus.dismiss = 1'b0;
        bus.snooze  = 1'b0;
        chk("t5_ds_r", bus.r, 1'b0);
        chk("t5_ds_snz", bus.snoozing, 1'b0);
        bus.alarmon = 1'b0;
        ring_2358();
        chk("t5_off_r", bus.r, 1'b0);
        bus.alarmon = 1'b1;
        ring_2358();
        chk("t5_on_r", bus.r, 1'b1);
        bus.alarmon = 1'b0;
        step(1);
        chk("t5_drop_r", bus.r, 1'b0);
        chk("t5_drop_missed", bus.missed, 1'b0);
        bus.alarmon = 1'b1;

        // 6: async reset mid-ring clears outputs at once and wipes slots
        ring_2358();
        chk("t6_ring", bus.r, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_r", bus.r, 1'b0);
        chk("t6_async_idx", bus.ring_idx, 2'd0);
        step(1);
        reset = 1'b0;
        step(2);
        ring_2358();
        chk("t6_cleared", bus.r, 1'b0);

        // 7: snooze without hour wrap, 10:20 + 5 -> 10:25
        wr(2'd0, 7'd10, 7'd20, 1'b1);
        bus.h = 7'd10;
        bus.m = 7'd19;
        step(2);
        bus.m = 7'd20;
        step(1);
        chk("t7_ring", bus.r, 1'b1);
        bus.snooze = 1'b1;
        step(1);
        bus.snooze = 1'b0;
        chk("t7_snz", bus.snoozing, 1'b1);
        bus.m = 7'd24;
        step(2);
        chk("t7_1024", bus.r, 1'b0);
        bus.m = 7'd25;
        step(1);
        chk("t7_1025", bus.r, 1'b1);
        pulse_dismiss();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
